pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered program-counter sequencer for the GCD datapath.
- Decodes a 4-bit branch opcode against the ALU zero/negative flags and owns the PC register.
- Adds run/halt/fault control and a parametrised-depth call/return stack.
- Sits between instruction memory (addressed by pc) and the datapath; sel is exported for the existing PC-source mux and for debug.

Parameters:
- PC_W, 8, program counter / branch address width.
- STACK_DEPTH, 4, call/return stack entries (>=1).
- BR_W, 4, branch opcode width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request / WAIT release.
- zero_flag  input  1  ALU result == 0.
- neg_flag  input  1  ALU result < 0.
- branch_instruction  input  BR_W  opcode of instruction at pc (combinational from imem).
- branch_addr  input  PC_W  target address field of instruction at pc.
- pc  output  PC_W  current program counter (registered).
- sel  output  4  next-PC source: 0 inc, 1 hold, 2 branch, 3 reset, 4 return (combinational).
- running  output  1  state==RUN.
- halted  output  1  state==HALTED.
- fault  output  1  state==FAULT.
- stack_level  output  $clog2(STACK_DEPTH+1)  occupied stack entries.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, sp=0, stack contents don't-care, all status outputs 0 except as decoded from IDLE.
- States: IDLE, RUN, HALTED, FAULT; registered.
- IDLE: pc held at 0, sel=1. start=1 -> RUN next edge. No opcode is executed in IDLE.
- RUN: one opcode per cycle; pc updates on the next edge.
  - 0 NOP: pc+1.
  - 1 WAIT: hold while start=0, else pc+1.
  - 2 BNZ: branch_addr if zero_flag=0, else pc+1.
  - 3 RST: pc=0, sp=0, stay RUN.
  - 4 JMP: branch_addr.
  - 5 BNEG: branch_addr if neg_flag=1, else pc+1.
  - 6 BZ: branch_addr if zero_flag=1, else pc+1.
  - 7 CALL: push pc+1, pc=branch_addr, sp+1.
  - 8 RET: pc=top, sp-1.
  - 9 HALT: pc held, -> HALTED.
  - 10-15: treated as NOP.
- pc+1 wraps modulo 2^PC_W (max -> 0), no flag.
- CALL with sp==STACK_DEPTH (overflow): no push, pc held, -> FAULT.
- RET with sp==0 (underflow): pc held, -> FAULT.
- HALTED: pc held, sel=1. start=0 -> IDLE; IDLE then resets pc to 0 on the transition.
- FAULT: sticky; pc and sp frozen, sel=1; exits only via rst_n.
- sel decode in non-RUN states is 1. In RUN it reflects the taken source, including 1 for a held WAIT.
- Flags are sampled in the same cycle as the opcode; no flag registering inside this block.
- Reset mid-operation: asynchronous clear regardless of state; stack is logically emptied via sp=0.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined: adds output taken_count [15:0]. It increments on every RUN cycle with sel==2 or sel==4, saturates at 16'hFFFF, and clears on rst_n and on opcode RST.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package pc_seq_pkg:
  - enum br_op_e (NOP..HALT).
  - enum seq_state_e.
  - enum pc_sel_e (INC, HOLD, BRANCH, RESET, RETURN).
  - localparam BR_W=4.
- Sub-module pc_stack: LIFO of STACK_DEPTH x PC_W.
  - Inputs: push, pop, din.
  - Outputs: top, level, full, empty.
  - Same clk/rst_n.
  - Sequencer checks full/empty before asserting push/pop.

Test Plan:
- Reset/start: rst_n low 2 cycles, start=0 5 cycles -> pc=0, sel=1, running=0. start=1 -> running=1 next edge; NOP stream gives pc 0,1,2,3.
- Conditional branches: BNZ addr=8'h20 with zero_flag=0 -> pc=8'h20; with zero_flag=1 -> pc+1. BNEG addr=8'h40 with neg_flag=1 -> 8'h40. BZ with zero_flag=1 -> target.
- Call/return: at pc=5, CALL 8'h30 -> pc=8'h30, stack_level=1. RET -> pc=6, stack_level=0. Nested CALLs to depth 4 then 4 RETs return in LIFO order.
- Stack faults: 5th nested CALL (DEPTH=4) -> fault=1, pc frozen, 10 cycles of any opcode leave pc unchanged. RET at stack_level=0 -> fault=1.
- Wrap/WAIT/HALT: pc=8'hFF NOP -> pc=8'h00. WAIT with start=0 holds pc 3 cycles, start=1 -> pc+1. HALT -> halted=1; start=0 -> IDLE with pc=0.
- Async reset mid-CALL sequence at stack_level=2 -> pc=0, stack_level=0, state IDLE immediately without a clock edge. With PC_SEQ_PERF_EN: 3 taken branches -> taken_count=3, RST -> 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the GCD program-counter sequencer: branch opcodes,
// sequencer states and next-PC source selects.
package pc_seq_pkg;

    localparam int BR_W = 4;

    typedef enum logic [BR_W-1:0] {
        OP_NOP  = 4'd0,
        OP_WAIT = 4'd1,
        OP_BNZ  = 4'd2,
        OP_RST  = 4'd3,
        OP_JMP  = 4'd4,
        OP_BNEG = 4'd5,
        OP_BZ   = 4'd6,
        OP_CALL = 4'd7,
        OP_RET  = 4'd8,
        OP_HALT = 4'd9
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED,
        ST_FAULT
    } seq_state_e;

    typedef enum logic [3:0] {
        SEL_INC    = 4'd0,
        SEL_HOLD   = 4'd1,
        SEL_BRANCH = 4'd2,
        SEL_RESET  = 4'd3,
        SEL_RETURN = 4'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_stack.sv
// Call/return LIFO of STACK_DEPTH return addresses; the caller guards
// push/pop with full/empty, and clear empties it logically.
module pc_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clear,
    input  logic                               push,
    input  logic                               pop,
    input  logic [PC_W-1:0]                    din,
    output logic [PC_W-1:0]                    top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
    output logic                               full,
    output logic                               empty
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  mem [STACK_DEPTH];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full   = (level == LVL_W'(STACK_DEPTH));
    assign empty  = (level == '0);
    assign wr_idx = IDX_W'(level);
    assign rd_idx = IDX_W'(level - LVL_W'(1));
    assign top    = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (clear) begin
            level <= '0;
        end else if (push && !full) begin
            level <= level + LVL_W'(1);
        end else if (pop && !empty) begin
            level <= level - LVL_W'(1);
        end
    end

    // Entries need no reset: only slots below level are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC sequencer with run/halt/fault control and call/return stack.
// Optional PC_SEQ_PERF_EN adds a saturating taken-branch counter.
module pc_sequencer #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    parameter int BR_W        = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               zero_flag,
    input  logic                               neg_flag,
    input  logic [BR_W-1:0]                    branch_instruction,
    input  logic [PC_W-1:0]                    branch_addr,
    output logic [PC_W-1:0]                    pc,
    output logic [3:0]                         sel,
    output logic                               running,
    output logic                               halted,
    output logic                               fault,
`ifdef PC_SEQ_PERF_EN
    output logic [15:0]                        taken_count,
`endif
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level
);

    import pc_seq_pkg::*;

    seq_state_e      state;
    seq_state_e      state_nx;
    pc_sel_e         sel_c;
    logic [PC_W-1:0] pc_nx;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stack_top;
    logic            push;
    logic            pop;
    logic            clear;
    logic            stack_full;
    logic            stack_empty;

    pc_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (stack_top),
        .level (stack_level),
        .full  (stack_full),
        .empty (stack_empty)
    );

    assign pc_inc  = pc + PC_W'(1);
    assign sel     = sel_c;
    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);
    assign fault   = (state == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        sel_c    = SEL_HOLD;
        push     = 1'b0;
        pop      = 1'b0;
        clear    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                pc_nx = '0;
                if (start) state_nx = ST_RUN;
            end
            ST_RUN: begin
                sel_c = SEL_INC;
                pc_nx = pc_inc;
                case (branch_instruction)
                    OP_WAIT: begin
                        if (!start) begin
                            sel_c = SEL_HOLD;
                            pc_nx = pc;
                        end
                    end
                    OP_BNZ: begin
                        if (!zero_flag) begin
                            sel_c = SEL_BRANCH;
                            pc_nx = branch_addr;
                        end
                    end
                    OP_RST: begin
                        sel_c = SEL_RESET;
                        pc_nx = '0;
                        clear = 1'b1;
                    end
                    OP_JMP: begin
                        sel_c = SEL_BRANCH;
                        pc_nx = branch_addr;
                    end
                    OP_BNEG: begin
                        if (neg_flag) begin
                            sel_c = SEL_BRANCH;
                            pc_nx = branch_addr;
                        end
                    end
                    OP_BZ: begin
                        if (zero_flag) begin
                            sel_c = SEL_BRANCH;
                            pc_nx = branch_addr;
                        end
                    end
                    // Overflow/underflow freeze the PC where the bad op sits for debug.
                    OP_CALL: begin
                        if (stack_full) begin
                            sel_c    = SEL_HOLD;
                            pc_nx    = pc;
                            state_nx = ST_FAULT;
                        end else begin
                            push  = 1'b1;
                            sel_c = SEL_BRANCH;
                            pc_nx = branch_addr;
                        end
                    end
                    OP_RET: begin
                        if (stack_empty) begin
                            sel_c    = SEL_HOLD;
                            pc_nx    = pc;
                            state_nx = ST_FAULT;
                        end else begin
                            pop   = 1'b1;
                            sel_c = SEL_RETURN;
                            pc_nx = stack_top;
                        end
                    end
                    OP_HALT: begin
                        sel_c    = SEL_HOLD;
                        pc_nx    = pc;
                        state_nx = ST_HALTED;
                    end
                    default: begin
                    end
                endcase
            end
            ST_HALTED: begin
                if (!start) begin
                    state_nx = ST_IDLE;
                    pc_nx    = '0;
                end
            end
            default: begin
            end
        endcase
    end

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_count <= '0;
        end else if (sel_c == SEL_RESET) begin
            taken_count <= '0;
        end else if ((sel_c == SEL_BRANCH || sel_c == SEL_RETURN) && taken_count != 16'hFFFF) begin
            taken_count <= taken_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan steps, then a
// randomized phase, all checked against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int DEPTH    = 4;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;
    localparam int M_FAULT  = 3;
    localparam int NOP = 0, WAIT = 1, BNZ = 2, RST = 3, JMP = 4;
    localparam int BNEG = 5, BZ = 6, CALL = 7, RET = 8, HALT = 9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       zero_flag = 1'b0;
    logic       neg_flag = 1'b0;
    logic [3:0] branch_instruction = 4'd0;
    logic [7:0] branch_addr = 8'd0;
    logic [7:0] pc;
    logic [3:0] sel;
    logic       running;
    logic       halted;
    logic       fault;
    logic [2:0] stack_level;
`ifdef PC_SEQ_PERF_EN
    logic [15:0] taken_count;
`endif

    int checks = 0;
    int failures = 0;

    int m_mode = M_IDLE;
    int m_pc = 0;
    int m_taken = 0;
    int m_stack[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W        (8),
        .STACK_DEPTH (DEPTH),
        .BR_W        (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .zero_flag          (zero_flag),
        .neg_flag           (neg_flag),
        .branch_instruction (branch_instruction),
        .branch_addr        (branch_addr),
        .pc                 (pc),
        .sel                (sel),
        .running            (running),
        .halted             (halted),
        .fault              (fault),
`ifdef PC_SEQ_PERF_EN
        .taken_count        (taken_count),
`endif
        .stack_level        (stack_level)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkValue("pc", 32'(pc), 32'(m_pc));
        checkValue("running", 32'(running), 32'(m_mode == M_RUN));
        checkValue("halted", 32'(halted), 32'(m_mode == M_HALTED));
        checkValue("fault", 32'(fault), 32'(m_mode == M_FAULT));
        checkValue("stack_level", 32'(stack_level), 32'(m_stack.size()));
`ifdef PC_SEQ_PERF_EN
        checkValue("taken_count", 32'(taken_count), 32'(m_taken));
`endif
    endtask

    // Behavioural model: advances one clock of the sequencer, returns the expected PC source.
    task automatic modelStep(input int op, input int addr, input logic st, input logic z,
                             input logic n, output int exp_sel);
        int next_pc;
        int inc;
        inc     = (m_pc + 1) % 256;
        next_pc = m_pc;
        exp_sel = 1;
        case (m_mode)
            M_IDLE:   if (st) m_mode = M_RUN;
            M_HALTED: if (!st) begin m_mode = M_IDLE; next_pc = 0; end
            M_RUN: begin
                exp_sel = 0;
                next_pc = inc;
                case (op)
                    WAIT: if (!st) begin exp_sel = 1; next_pc = m_pc; end
                    BNZ:  if (!z) begin exp_sel = 2; next_pc = addr; end
                    RST:  begin exp_sel = 3; next_pc = 0; m_stack.delete(); end
                    JMP:  begin exp_sel = 2; next_pc = addr; end
                    BNEG: if (n) begin exp_sel = 2; next_pc = addr; end
                    BZ:   if (z) begin exp_sel = 2; next_pc = addr; end
                    CALL: begin
                        if (m_stack.size() == DEPTH) begin
                            exp_sel = 1; next_pc = m_pc; m_mode = M_FAULT;
                        end else begin
                            m_stack.push_back(inc); exp_sel = 2; next_pc = addr;
                        end
                    end
                    RET: begin
                        if (m_stack.size() == 0) begin
                            exp_sel = 1; next_pc = m_pc; m_mode = M_FAULT;
                        end else begin
                            exp_sel = 4; next_pc = m_stack.pop_back();
                        end
                    end
                    HALT: begin exp_sel = 1; next_pc = m_pc; m_mode = M_HALTED; end
                    default: begin end
                endcase
                if (op == RST) m_taken = 0;
                else if ((exp_sel == 2 || exp_sel == 4) && m_taken < 65535) m_taken++;
            end
            default: begin end
        endcase
        m_pc = next_pc;
    endtask

    task automatic applyStimulus(input int op, input int addr, input logic st,
                                 input logic z, input logic n);
        int exp_sel;
        @(negedge clk);
        branch_instruction = 4'(op);
        branch_addr        = 8'(addr);
        start              = st;
        zero_flag          = z;
        neg_flag           = n;
        #1;
        modelStep(op, addr, st, z, n, exp_sel);
        checkValue("sel", 32'(sel), 32'(exp_sel));
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Asserts rst_n mid-cycle and checks the clear before any clock edge.
    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n              = 1'b0;
        start              = 1'b0;
        branch_instruction = 4'd0;
        #1;
        m_mode = M_IDLE;
        m_pc   = 0;
        m_taken = 0;
        m_stack.delete();
        checkOutput();
        checkValue("reset_sel", 32'(sel), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] pc_sequencer bench start");

        doReset();
        repeat (5) applyStimulus(NOP, 0, 1'b0, 1'b0, 1'b0);
        checkValue("idle_pc", 32'(pc), 32'h0);
        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        repeat (3) applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        checkValue("nop_pc", 32'(pc), 32'h3);

        applyStimulus(BNZ, 'h20, 1'b1, 1'b0, 1'b0);
        checkValue("bnz_taken", 32'(pc), 32'h20);
        applyStimulus(BNZ, 'h20, 1'b1, 1'b1, 1'b0);
        checkValue("bnz_not_taken", 32'(pc), 32'h21);
        applyStimulus(BNEG, 'h40, 1'b1, 1'b0, 1'b1);
        checkValue("bneg_taken", 32'(pc), 32'h40);
        applyStimulus(BZ, 'h10, 1'b1, 1'b1, 1'b0);
        checkValue("bz_taken", 32'(pc), 32'h10);

        applyStimulus(JMP, 5, 1'b1, 1'b0, 1'b0);
        applyStimulus(CALL, 'h30, 1'b1, 1'b0, 1'b0);
        checkValue("call_pc", 32'(pc), 32'h30);
        checkValue("call_level", 32'(stack_level), 32'd1);
        applyStimulus(RET, 0, 1'b1, 1'b0, 1'b0);
        checkValue("ret_pc", 32'(pc), 32'h6);

        applyStimulus(JMP, 'h10, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(CALL, 'h50 + 'h10 * i, 1'b1, 1'b0, 1'b0);
        checkValue("nest_level", 32'(stack_level), 32'd4);
        for (int i = 0; i < 4; i++) applyStimulus(RET, 0, 1'b1, 1'b0, 1'b0);
        checkValue("lifo_pc", 32'(pc), 32'h11);

        for (int i = 0; i < 4; i++) applyStimulus(CALL, 'h50 + 'h10 * i, 1'b1, 1'b0, 1'b0);
        applyStimulus(CALL, 'h90, 1'b1, 1'b0, 1'b0);
        checkValue("overflow_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 10; i++)
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                          1'($urandom), 1'($urandom), 1'($urandom));
        checkValue("fault_frozen_pc", 32'(pc), 32'h80);

        doReset();
        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(RET, 0, 1'b1, 1'b0, 1'b0);
        checkValue("underflow_fault", 32'(fault), 32'd1);

        doReset();
        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(JMP, 'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        checkValue("wrap_pc", 32'(pc), 32'h0);
        repeat (3) applyStimulus(WAIT, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(WAIT, 0, 1'b1, 1'b0, 1'b0);
        checkValue("wait_release_pc", 32'(pc), 32'h1);
        applyStimulus(HALT, 0, 1'b1, 1'b0, 1'b0);
        checkValue("halt_flag", 32'(halted), 32'd1);
        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(NOP, 0, 1'b0, 1'b0, 1'b0);
        checkValue("halt_to_idle_pc", 32'(pc), 32'h0);

        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(CALL, 'h30, 1'b1, 1'b0, 1'b0);
        applyStimulus(CALL, 'h40, 1'b1, 1'b0, 1'b0);
        checkValue("pre_reset_level", 32'(stack_level), 32'd2);
        doReset();

        applyStimulus(NOP, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(JMP, 'h20 + i, 1'b1, 1'b0, 1'b0);
`ifdef PC_SEQ_PERF_EN
        checkValue("taken_three", 32'(taken_count), 32'd3);
`endif
        applyStimulus(RST, 0, 1'b1, 1'b0, 1'b0);
`ifdef PC_SEQ_PERF_EN
        checkValue("taken_cleared", 32'(taken_count), 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            if (i % 30 == 0) doReset();
            applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
